// File: rtl/iic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iic_pkg
// Description : Shared definitions for the IIC command scheduler: scheduler
//               FSM state encoding, command word layout and access type codes.
// Contents    : iic_state_t, IIC_CMD_W, field bit offsets, IIC_WR / IIC_RD
// Revision    : 1.0 - initial release
// ============================================================================
package iic_pkg;

    // Queued command word: {wr_rd, dev_addr[7:0], reg[15:0], data[7:0]}
    localparam int IIC_CMD_W    = 33;
    localparam int IIC_RW_BIT   = 32;
    localparam int IIC_DEV_LSB  = 24;
    localparam int IIC_REG_LSB  = 8;
    localparam int IIC_DATA_LSB = 0;

    localparam logic IIC_WR = 1'b0;
    localparam logic IIC_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_CHECK     = 3'd5,
        ST_GAP       = 3'd6
    } iic_state_t;

endpackage
`default_nettype wire

// File: rtl/iic_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iic_cmd_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               visible on o_dout whenever o_empty is low.
// Ports       : clk_i, rst (async, active-high)
//               i_push/i_din  - write side (ignored when full)
//               i_pop         - consume head (ignored when empty)
//               o_dout        - head entry
//               o_full, o_empty, o_count (log2(DEPTH)+1 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module iic_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/iic_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : iic_cmd_sched
// Description : Queues I2C register commands, issues them one at a time to
//               the byte driver over start_en/busy, retries failed attempts
//               and returns exactly one response per command.
// Ports       : clk_i, rst (async, active-high)
//               cmd_*            - command input (valid/ready)
//               start_en, wr_rd_flag, i2c_device_addr, register, data_byte
//                                - driver command interface
//               busy, err, rd_data - driver status
//               rsp_*            - response pulse and fields
//               sched_busy       - queue non-empty or transfer in progress
// Revision    : 1.0 - initial release
// ============================================================================
module iic_cmd_sched
    import iic_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int GAP_CYC   = 4,
    parameter int BUSY_TO   = 16
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr_rd,
    input  logic [7:0]  cmd_dev_addr,
    input  logic [15:0] cmd_reg,
    input  logic [7:0]  cmd_data,
    output logic        start_en,
    output logic        wr_rd_flag,
    output logic [7:0]  i2c_device_addr,
    output logic [15:0] register,
    output logic [7:0]  data_byte,
    input  logic        busy,
    input  logic        err,
    input  logic [7:0]  rd_data,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_reg,
    output logic [7:0]  rsp_data,
    output logic        sched_busy
);

    // One counter serves both the busy timeout and the inter-start gap.
    localparam int CNT_W = $clog2(BUSY_TO + GAP_CYC + 1);
    localparam int ATT_W = $clog2(MAX_RETRY + 2);

    iic_state_t               r_state;
    iic_state_t               w_next;
    logic [CNT_W-1:0]         r_cnt;
    logic [ATT_W-1:0]         r_attempt;
    logic                     r_fail;
    logic [7:0]               r_rd_data;
    logic                     r_seen_low;
    logic                     r_retry;
    logic                     r_wr_rd;
    logic [7:0]               r_dev;
    logic [15:0]              r_reg;
    logic [7:0]               r_data;

    logic [IIC_CMD_W-1:0]     w_din;
    logic [IIC_CMD_W-1:0]     w_dout;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_final;
    logic                     w_busy_to;
    logic                     w_gap_done;
    logic                     w_busy_rise;

    assign w_din  = {cmd_wr_rd, cmd_dev_addr, cmd_reg, cmd_data};
    assign w_push = cmd_valid & ~w_full;
    assign w_pop  = (r_state == ST_LOAD);

    iic_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IIC_CMD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A command is finished on success or once the last allowed attempt failed.
    assign w_final     = ~r_fail | (r_attempt == ATT_W'(MAX_RETRY));
    assign w_busy_to   = (r_cnt == CNT_W'(BUSY_TO - 1));
    assign w_gap_done  = (r_cnt == CNT_W'(GAP_CYC - 1));
    // busy only counts as "started" once it has been observed low after START,
    // so a driver still holding busy from a previous transfer is not mistaken
    // for an acknowledgement.
    assign w_busy_rise = busy & r_seen_low;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (!w_empty) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_START;
            ST_START:     w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (w_busy_rise)    w_next = ST_WAIT_DONE;
                else if (w_busy_to) w_next = ST_CHECK;
            end
            ST_WAIT_DONE: if (!busy) w_next = ST_CHECK;
            ST_CHECK:     w_next = ST_GAP;
            ST_GAP: begin
                if (w_gap_done) begin
                    if (r_retry)       w_next = ST_START;
                    else if (!w_empty) w_next = ST_LOAD;
                    else               w_next = ST_IDLE;
                end
            end
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_attempt  <= '0;
            r_fail     <= 1'b0;
            r_rd_data  <= '0;
            r_seen_low <= 1'b0;
            r_retry    <= 1'b0;
            r_wr_rd    <= 1'b0;
            r_dev      <= '0;
            r_reg      <= '0;
            r_data     <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_wr_rd   <= w_dout[IIC_RW_BIT];
                    r_dev     <= w_dout[IIC_DEV_LSB +: 8];
                    r_reg     <= w_dout[IIC_REG_LSB +: 16];
                    r_data    <= w_dout[IIC_DATA_LSB +: 8];
                    r_attempt <= '0;
                    r_retry   <= 1'b0;
                end
                ST_START: begin
                    r_cnt      <= '0;
                    r_seen_low <= ~busy;
                    r_fail     <= 1'b0;
                    r_rd_data  <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (!w_busy_rise) begin
                        if (!busy) r_seen_low <= 1'b1;
                        if (w_busy_to) r_fail <= 1'b1;
                        else           r_cnt  <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // Falling edge of busy: the only point where err is valid.
                    if (!busy) begin
                        r_fail    <= err;
                        r_rd_data <= rd_data;
                    end
                end
                ST_CHECK: begin
                    r_cnt <= '0;
                    if (w_final) begin
                        r_retry <= 1'b0;
                    end else begin
                        r_retry   <= 1'b1;
                        r_attempt <= r_attempt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (!w_gap_done) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready       = ~w_full;
    assign start_en        = (r_state == ST_START);
    assign wr_rd_flag      = r_wr_rd;
    assign i2c_device_addr = r_dev;
    assign register        = r_reg;
    assign data_byte       = r_data;
    assign rsp_valid       = (r_state == ST_CHECK) & w_final;
    assign rsp_err         = rsp_valid & r_fail;
    assign rsp_reg         = r_reg;
    assign rsp_data        = (rsp_valid & ~r_fail & (r_wr_rd == IIC_RD)) ? r_rd_data : 8'h00;
    assign sched_busy      = (w_count != '0) | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iic_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_iic_cmd_sched
// Description : Directed self-checking bench for iic_cmd_sched with a simple
//               cycle-based I2C driver model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iic_cmd_sched;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_wr_rd;
    logic [7:0]  cmd_dev_addr, cmd_data;
    logic [15:0] cmd_reg;
    logic        start_en, wr_rd_flag;
    logic [7:0]  i2c_device_addr, data_byte;
    logic [15:0] register;
    logic        rsp_valid, rsp_err, sched_busy;
    logic [15:0] rsp_reg;
    logic [7:0]  rsp_data;

    // Driver model state and configuration
    logic        m_busy = 1'b0;
    logic        m_err  = 1'b0;
    logic [7:0]  m_rd   = 8'h00;
    int          m_phase = 0;
    int          m_cnt   = 0;
    int          m_att   = 0;
    int          cfg_len;
    logic [3:0]  cfg_err_seq;
    logic [7:0]  cfg_rd;
    logic        cfg_never;

    // Monitor state
    logic        clr = 1'b0;
    int          cyc = 0;
    int          n_start = 0;
    int          n_rsp = 0;
    int          last_start = -1;
    int          last_rsp = -1;
    int          sp_q[$];
    int          ss_q[$];
    int          lat_q[$];
    logic [24:0] rsp_q[$];

    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk_i = ~clk_i;

    iic_cmd_sched #(
        .DEPTH(8), .MAX_RETRY(3), .GAP_CYC(4), .BUSY_TO(16)
    ) dut (
        .clk_i           (clk_i),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_wr_rd       (cmd_wr_rd),
        .cmd_dev_addr    (cmd_dev_addr),
        .cmd_reg         (cmd_reg),
        .cmd_data        (cmd_data),
        .start_en        (start_en),
        .wr_rd_flag      (wr_rd_flag),
        .i2c_device_addr (i2c_device_addr),
        .register        (register),
        .data_byte       (data_byte),
        .busy            (m_busy),
        .err             (m_err),
        .rd_data         (m_rd),
        .rsp_valid       (rsp_valid),
        .rsp_err         (rsp_err),
        .rsp_reg         (rsp_reg),
        .rsp_data        (rsp_data),
        .sched_busy      (sched_busy)
    );

    // Driver: busy rises two cycles after start_en, stays high cfg_len cycles,
    // then falls with err taken from cfg_err_seq[attempt].
    always @(posedge clk_i) begin
        if (rst) begin
            m_phase <= 0;
            m_busy  <= 1'b0;
            m_att   <= 0;
            m_cnt   <= 0;
        end else begin
            if (rsp_valid) m_att <= 0;
            case (m_phase)
                0: if (start_en && !cfg_never) begin
                    m_phase <= 1;
                    m_cnt   <= 1;
                end
                1: if (m_cnt == 0) begin
                    m_busy  <= 1'b1;
                    m_cnt   <= cfg_len - 1;
                    m_phase <= 2;
                end else m_cnt <= m_cnt - 1;
                2: if (m_cnt == 0) begin
                    m_busy  <= 1'b0;
                    m_err   <= cfg_err_seq[m_att];
                    m_rd    <= cfg_rd;
                    m_att   <= m_att + 1;
                    m_phase <= 0;
                end else m_cnt <= m_cnt - 1;
                default: m_phase <= 0;
            endcase
        end
    end

    // Monitor: start/response counts, response contents and cycle spacings.
    always @(negedge clk_i) begin
        cyc++;
        if (clr) begin
            n_start = 0; n_rsp = 0; last_start = -1; last_rsp = -1;
            sp_q.delete(); ss_q.delete(); lat_q.delete(); rsp_q.delete();
        end else begin
            if (start_en) begin
                n_start++;
                if (last_rsp >= 0)   sp_q.push_back(cyc - last_rsp);
                if (last_start >= 0) ss_q.push_back(cyc - last_start);
                last_start = cyc;
            end
            if (rsp_valid) begin
                n_rsp++;
                rsp_q.push_back({rsp_err, rsp_reg, rsp_data});
                lat_q.push_back(cyc - last_start);
                last_rsp = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk_i);
        #1;
        clr = 1'b0;
        tick();
    endtask

    task automatic push(input logic wr, input logic [7:0] dev, input logic [15:0] rg, input logic [7:0] dat);
        cmd_valid = 1'b1; cmd_wr_rd = wr; cmd_dev_addr = dev; cmd_reg = rg; cmd_data = dat;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string tag);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (!sched_busy) break;
        end
        check(tag, sched_busy, 0);
    endtask

    initial begin
        cmd_valid = 0; cmd_wr_rd = 0; cmd_dev_addr = 0; cmd_reg = 0; cmd_data = 0;
        cfg_len = 40; cfg_err_seq = 4'b0000; cfg_rd = 8'h00; cfg_never = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_ctrl", {start_en, rsp_valid, rsp_err, sched_busy}, 0);
        check("rst_fields", {wr_rd_flag, i2c_device_addr, register, data_byte, rsp_reg, rsp_data}, 0);
        rst = 1'b0;
        tick();

        // Single write: start latency, fields, response
        clear_mon();
        push(1'b0, 8'h78, 16'h3008, 8'h82);
        check("t1_busy_flag", sched_busy, 1);
        tick();
        check("t1_load_nostart", start_en, 0);
        tick();
        check("t1_start", start_en, 1);
        check("t1_fields", {wr_rd_flag, i2c_device_addr, register, data_byte}, {1'b0, 8'h78, 16'h3008, 8'h82});
        wait_idle(200, "t1_idle");
        check("t1_nstart", n_start, 1);
        check("t1_nrsp", n_rsp, 1);
        if (rsp_q.size() > 0) check("t1_rsp", rsp_q[0], {1'b0, 16'h3008, 8'h00});
        if (lat_q.size() > 0) check("t1_rsp_lat", lat_q[0], 44);
        check("t1_held", {i2c_device_addr, register, data_byte}, {8'h78, 16'h3008, 8'h82});

        // Single read
        clear_mon();
        cfg_rd = 8'h56;
        push(1'b1, 8'h79, 16'h300A, 8'h00);
        tick();
        tick();
        check("t2_start", start_en, 1);
        check("t2_rdflag_start", wr_rd_flag, 1);
        wait_idle(200, "t2_idle");
        check("t2_nrsp", n_rsp, 1);
        if (rsp_q.size() > 0) check("t2_rsp", rsp_q[0], {1'b0, 16'h300A, 8'h56});
        check("t2_rdflag_end", wr_rd_flag, 1);

        // Nine back-to-back commands into an 8-deep queue
        clear_mon();
        cfg_len = 5;
        cfg_rd  = 8'hA5;
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1; cmd_wr_rd = i[0]; cmd_dev_addr = 8'h50;
            cmd_reg = 16'(16'h1000 + i); cmd_data = 8'(i);
            check("t3_ready_pre", cmd_ready, 1);
            tick();
        end
        cmd_valid = 1'b0;
        check("t3_full", cmd_ready, 0);
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) break;
            tick();
        end
        check("t3_first_rsp", rsp_valid, 1);
        repeat (5) tick();
        check("t3_load_still_full", cmd_ready, 0);
        tick();
        check("t3_pop_ready", cmd_ready, 1);
        wait_idle(1000, "t3_idle");
        check("t3_nrsp", n_rsp, 9);
        for (int i = 0; i < rsp_q.size(); i++)
            check($sformatf("t3_rsp%0d", i), rsp_q[i], {1'b0, 16'(16'h1000 + i), (i[0] ? 8'hA5 : 8'h00)});
        check("t3_nsp", sp_q.size(), 8);
        for (int i = 0; i < sp_q.size(); i++)
            check($sformatf("t3_space%0d", i), sp_q[i], 6);

        // Two failed attempts then success
        clear_mon();
        cfg_err_seq = 4'b0011;
        push(1'b0, 8'h42, 16'h2000, 8'h11);
        wait_idle(500, "t4a_idle");
        check("t4a_nstart", n_start, 3);
        check("t4a_nrsp", n_rsp, 1);
        if (rsp_q.size() > 0) check("t4a_rsp", rsp_q[0], {1'b0, 16'h2000, 8'h00});
        check("t4a_nss", ss_q.size(), 2);
        for (int i = 0; i < ss_q.size(); i++)
            check($sformatf("t4a_retry_space%0d", i), ss_q[i], 14);

        // Every attempt fails
        clear_mon();
        cfg_err_seq = 4'b1111;
        cfg_rd = 8'h77;
        push(1'b1, 8'h42, 16'h2002, 8'h00);
        wait_idle(500, "t4b_idle");
        check("t4b_nstart", n_start, 4);
        check("t4b_nrsp", n_rsp, 1);
        if (rsp_q.size() > 0) check("t4b_rsp", rsp_q[0], {1'b1, 16'h2002, 8'h00});

        // Driver never responds: busy timeout on each attempt
        clear_mon();
        cfg_never = 1'b1;
        cfg_err_seq = 4'b0000;
        push(1'b0, 8'h42, 16'h2004, 8'h33);
        wait_idle(500, "t5_idle");
        check("t5_nstart", n_start, 4);
        check("t5_nrsp", n_rsp, 1);
        if (rsp_q.size() > 0) check("t5_rsp", rsp_q[0], {1'b1, 16'h2004, 8'h00});
        check("t5_nss", ss_q.size(), 3);
        for (int i = 0; i < ss_q.size(); i++)
            check($sformatf("t5_to_space%0d", i), ss_q[i], 22);
        if (lat_q.size() > 0) check("t5_to_lat", lat_q[0], 17);

        // Reset during WAIT_DONE with commands still queued
        clear_mon();
        cfg_never = 1'b0;
        cfg_len = 40;
        push(1'b0, 8'h10, 16'h4000, 8'h01);
        push(1'b0, 8'h10, 16'h4001, 8'h02);
        push(1'b0, 8'h10, 16'h4002, 8'h03);
        for (int i = 0; i < 20; i++) begin
            if (m_busy) break;
            tick();
        end
        check("t6_busy_seen", m_busy, 1);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_ctrl", {start_en, rsp_valid, rsp_err, sched_busy}, 0);
        check("t6_ready", cmd_ready, 1);
        check("t6_fields", {wr_rd_flag, i2c_device_addr, register, data_byte, rsp_reg, rsp_data}, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (60) tick();
        check("t6_nrsp", n_rsp, 0);
        check("t6_nstart", n_start, 1);
        check("t6_idle", sched_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
